// File: rtl/reg_file_dw.sv
// reg_file_dw: parametrised register file with two read ports and two write
// ports, optional same-cycle write-to-read bypass, a register that keeps its
// contents through reset, and registered error reporting with a saturating
// event counter.
module reg_file_dw #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int BYPASS       = 1,
  parameter int PRESERVE_EN  = 1,
  parameter int PRESERVE_IDX = 29,
  parameter int CNT_W        = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              wa_en_i,
  input  logic [ADDR_W-1:0] wa_addr_i,
  input  logic [DATA_W-1:0] wa_data_i,
  input  logic              wa_exempt_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              wb_exempt_i,
  input  logic              err_clr_i,
  output logic              err_zero_o,
  output logic              err_conflict_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  // Two guard bits: the counter base plus up to two events per cycle.
  localparam int SUM_W = CNT_W + 2;

  // ---------------------------------------------------------------------------
  // Write-port qualification and error-event decode
  // ---------------------------------------------------------------------------
  logic w_wa_act;     // port A performs a real write this cycle
  logic w_wb_act;     // port B performs a real write this cycle
  logic w_zero_a;     // port A: non-exempt write aimed at register 0
  logic w_zero_b;     // port B: non-exempt write aimed at register 0
  logic w_conflict;   // both ports target the same non-zero register
  logic [1:0] w_events;

  assign w_wa_act   = wa_en_i && (wa_addr_i != '0);
  assign w_wb_act   = wb_en_i && (wb_addr_i != '0);
  assign w_zero_a   = wa_en_i && (wa_addr_i == '0) && !wa_exempt_i;
  assign w_zero_b   = wb_en_i && (wb_addr_i == '0) && !wb_exempt_i;
  assign w_conflict = w_wa_act && w_wb_act && (wa_addr_i == wb_addr_i);

  // A conflict needs non-zero addresses on both ports, so it never coincides
  // with a zero write and the sum is bounded by 2.
  assign w_events = {1'b0, w_zero_a} + {1'b0, w_zero_b} + {1'b0, w_conflict};

  // ---------------------------------------------------------------------------
  // Storage: one register per generate slot, entry 0 hard-wired to zero
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0][DATA_W-1:0] w_regs;

  assign w_regs[0] = '0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_reg
    localparam bit KEEP = (PRESERVE_EN != 0) && (g == PRESERVE_IDX);

    logic [DATA_W-1:0] r_q;
    logic              w_hit_a;
    logic              w_hit_b;

    assign w_hit_a = wa_en_i && (wa_addr_i == ADDR_W'(g));
    assign w_hit_b = wb_en_i && (wb_addr_i == ADDR_W'(g));

    // Register update: reset clears (unless preserved), port B wins a conflict.
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        if (!KEEP) begin
          r_q <= '0;
        end
      end else if (w_hit_b) begin
        r_q <= wb_data_i;
      end else if (w_hit_a) begin
        r_q <= wa_data_i;
      end
    end

    assign w_regs[g] = r_q;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_ra_stored;
  logic [DATA_W-1:0] w_rb_stored;

  assign w_ra_stored = w_regs[ra_addr_i];
  assign w_rb_stored = w_regs[rb_addr_i];

  if (BYPASS != 0) begin : g_bypass
    // Forward in-flight write data; the *_act terms already exclude address 0,
    // so a read of register 0 always falls through to the stored zero.
    assign ra_data_o = (w_wb_act && (wb_addr_i == ra_addr_i)) ? wb_data_i :
                       (w_wa_act && (wa_addr_i == ra_addr_i)) ? wa_data_i :
                       w_ra_stored;
    assign rb_data_o = (w_wb_act && (wb_addr_i == rb_addr_i)) ? wb_data_i :
                       (w_wa_act && (wa_addr_i == rb_addr_i)) ? wa_data_i :
                       w_rb_stored;
  end else begin : g_no_bypass
    // Stored value only: no path from the write inputs to the read outputs.
    assign ra_data_o = w_ra_stored;
    assign rb_data_o = w_rb_stored;
  end

  // ---------------------------------------------------------------------------
  // Error reporting
  // ---------------------------------------------------------------------------
  logic              r_err_zero;
  logic              r_err_conflict;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [SUM_W-1:0]  w_cnt_base;
  logic [SUM_W-1:0]  w_cnt_sum;
  logic [CNT_W-1:0]  w_cnt_next;

  // A clear restarts from zero but still counts this cycle's events.
  assign w_cnt_base = err_clr_i ? '0 : {2'b00, r_err_cnt};
  assign w_cnt_sum  = w_cnt_base + {{CNT_W{1'b0}}, w_events};
  assign w_cnt_next = (w_cnt_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                           : w_cnt_sum[CNT_W-1:0];

  // Error flags pulse for the cycle after the offending edge; counter saturates.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_err_zero     <= 1'b0;
      r_err_conflict <= 1'b0;
      r_err_cnt      <= '0;
    end else begin
      r_err_zero     <= w_zero_a || w_zero_b;
      r_err_conflict <= w_conflict;
      r_err_cnt      <= w_cnt_next;
    end
  end

  assign err_zero_o     = r_err_zero;
  assign err_conflict_o = r_err_conflict;
  assign err_cnt_o      = r_err_cnt;

endmodule

// File: tb/tb_reg_file_dw.sv
// Bench for reg_file_dw. Two instances share one stimulus stream:
//   u_dut1: defaults (bypass on, r29 preserved, 8-bit counter)
//   u_dut2: bypass off, nothing preserved, 2-bit counter
// Expected values come from an array-based model of the register file rules.
module tb_reg_file_dw;

  logic        clk;
  logic        rst;
  logic [4:0]  ra_addr, rb_addr;
  logic        wa_en, wa_exempt, wb_en, wb_exempt, err_clr;
  logic [4:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;

  logic [31:0] ra1, rb1, ra2, rb2;
  logic        ez1, ec1, ez2, ec2;
  logic [7:0]  cnt1;
  logic [1:0]  cnt2;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  reg_file_dw u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .ra_addr_i(ra_addr), .rb_addr_i(rb_addr),
    .ra_data_o(ra1), .rb_data_o(rb1),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data), .wa_exempt_i(wa_exempt),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_exempt_i(wb_exempt),
    .err_clr_i(err_clr),
    .err_zero_o(ez1), .err_conflict_o(ec1), .err_cnt_o(cnt1)
  );

  reg_file_dw #(.BYPASS(0), .PRESERVE_EN(0), .CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .ra_addr_i(ra_addr), .rb_addr_i(rb_addr),
    .ra_data_o(ra2), .rb_data_o(rb2),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data), .wa_exempt_i(wa_exempt),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_exempt_i(wb_exempt),
    .err_clr_i(err_clr),
    .err_zero_o(ez2), .err_conflict_o(ec2), .err_cnt_o(cnt2)
  );

  // ---------------- reference model ----------------
  logic [31:0] m1 [32];
  logic [31:0] m2 [32];
  bit          m1_known29;
  bit          model_valid;
  int          m1_cnt, m2_cnt;
  bit          m_ez, m_ec;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Value a read should return right now, by the register-file rules.
  function automatic logic [31:0] exp_rd(input bit bypass, input bit inst1, input int addr);
    if (addr == 0) return 32'h0;
    if (bypass) begin
      if (wb_en && int'(wb_addr) == addr) return wb_data;
      if (wa_en && int'(wa_addr) == addr) return wa_data;
    end
    return inst1 ? m1[addr] : m2[addr];
  endfunction

  // What happens at a rising edge, given the currently applied inputs.
  task automatic model_edge();
    int ev;
    bit za, zb, cf;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        if (i != 29) m1[i] = 32'h0;
        m2[i] = 32'h0;
      end
      m_ez = 0; m_ec = 0; m1_cnt = 0; m2_cnt = 0;
      model_valid = 1;
      return;
    end
    za = wa_en && wa_addr == 0 && !wa_exempt;
    zb = wb_en && wb_addr == 0 && !wb_exempt;
    cf = wa_en && wb_en && wa_addr == wb_addr && wa_addr != 0;
    ev = int'(za) + int'(zb) + int'(cf);
    if (wa_en && wa_addr != 0) begin
      m1[wa_addr] = wa_data; m2[wa_addr] = wa_data;
      if (wa_addr == 29) m1_known29 = 1;
    end
    if (wb_en && wb_addr != 0) begin
      m1[wb_addr] = wb_data; m2[wb_addr] = wb_data;
      if (wb_addr == 29) m1_known29 = 1;
    end
    m_ez = za || zb;
    m_ec = cf;
    m1_cnt = (err_clr ? 0 : m1_cnt) + ev;
    if (m1_cnt > 255) m1_cnt = 255;
    m2_cnt = (err_clr ? 0 : m2_cnt) + ev;
    if (m2_cnt > 3) m2_cnt = 3;
  endtask

  task automatic check_reads();
    if (!model_valid) return;
    if (!(ra_addr == 29 && !m1_known29)) chk("ra1", ra1, exp_rd(1'b1, 1'b1, int'(ra_addr)));
    if (!(rb_addr == 29 && !m1_known29)) chk("rb1", rb1, exp_rd(1'b1, 1'b1, int'(rb_addr)));
    chk("ra2", ra2, exp_rd(1'b0, 1'b0, int'(ra_addr)));
    chk("rb2", rb2, exp_rd(1'b0, 1'b0, int'(rb_addr)));
  endtask

  task automatic check_errs();
    chk("ez1",  {31'b0, ez1}, {31'b0, m_ez});
    chk("ec1",  {31'b0, ec1}, {31'b0, m_ec});
    chk("cnt1", {24'b0, cnt1}, m1_cnt);
    chk("ez2",  {31'b0, ez2}, {31'b0, m_ez});
    chk("ec2",  {31'b0, ec2}, {31'b0, m_ec});
    chk("cnt2", {30'b0, cnt2}, m2_cnt);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    rst = 1'b1; err_clr = 1'b0;
    wa_en = 1'b0; wa_exempt = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_exempt = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  // Inputs are set by the caller just after an edge; check reads mid-cycle,
  // take the edge, then check the registered outputs.
  task automatic step();
    #3;
    check_reads();
    @(posedge clk);
    model_edge();
    #1;
    if (model_valid) check_errs();
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [31:0] d, input logic ex);
    wa_en = 1'b1; wa_addr = a; wa_data = d; wa_exempt = ex;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [31:0] d, input logic ex);
    wb_en = 1'b1; wb_addr = a; wb_data = d; wb_exempt = ex;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    ra_addr = a; rb_addr = b;
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    m1_known29 = 0; model_valid = 0;
    m1_cnt = 0; m2_cnt = 0; m_ez = 0; m_ec = 0;
    idle_in(); rd(5'd0, 5'd0);

    // initial reset
    rst = 1'b0; step();
    idle_in(); step();

    // preload r29 and r5, reset, read back
    wr_a(5'd29, 32'h7FFC, 1'b0); wr_b(5'd5, 32'h1234, 1'b0); step();
    idle_in(); rst = 1'b0; rd(5'd29, 5'd5); step();
    idle_in(); step();

    // dual write, then read back
    wr_a(5'd3, 32'hAAAA, 1'b0); wr_b(5'd7, 32'h5555, 1'b0); rd(5'd1, 5'd2); step();
    idle_in(); rd(5'd3, 5'd7); step();

    // conflict on r9
    wr_a(5'd9, 32'h1111, 1'b0); wr_b(5'd9, 32'h2222, 1'b0); step();
    idle_in(); rd(5'd9, 5'd9); step();

    // zero writes: one exempt, then both non-exempt
    wr_a(5'd0, 32'hDEAD, 1'b0); wr_b(5'd0, 32'hBEEF, 1'b1); rd(5'd0, 5'd0); step();
    idle_in(); wr_a(5'd0, 32'h1, 1'b0); wr_b(5'd0, 32'h2, 1'b0); step();
    idle_in(); step();

    // bypass: r4 write visible on ra for dut1 only before the edge
    wr_a(5'd4, 32'h0000_00AA, 1'b0); step();
    idle_in(); wr_a(5'd4, 32'hBEEF, 1'b0); rd(5'd4, 5'd4); step();
    idle_in(); step();

    // counter saturation on the 2-bit instance, clear with event, reset with event
    idle_in(); rst = 1'b0; step();
    idle_in(); wr_a(5'd0, 32'h0, 1'b0); wr_b(5'd0, 32'h0, 1'b0); step();
    idle_in(); wr_a(5'd0, 32'h0, 1'b0); wr_b(5'd0, 32'h0, 1'b0); step();
    idle_in(); wr_a(5'd0, 32'h0, 1'b0); step();
    idle_in(); err_clr = 1'b1; wr_a(5'd0, 32'h0, 1'b0); step();
    idle_in(); rst = 1'b0; wr_a(5'd0, 32'h0, 1'b0); step();
    idle_in(); step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle_in();
      rst       = ($urandom_range(0, 39) != 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      wa_en     = ($urandom_range(0, 2) != 0);
      wb_en     = ($urandom_range(0, 2) != 0);
      wa_addr   = rnd_addr();
      wb_addr   = ($urandom_range(0, 4) == 0) ? wa_addr : rnd_addr();
      wa_data   = $urandom;
      wb_data   = $urandom;
      wa_exempt = ($urandom_range(0, 3) == 0);
      wb_exempt = ($urandom_range(0, 3) == 0);
      ra_addr   = ($urandom_range(0, 3) == 0) ? wa_addr : rnd_addr();
      rb_addr   = ($urandom_range(0, 3) == 0) ? wb_addr : rnd_addr();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
